// File: rtl/csr_file_pkg.sv
// ============================================================================
//  Module      : csr_file_pkg
//  Description : CSR address map, mstatus bit positions and shared helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_file_pkg;

    localparam logic [31:0] CSR_ADDR_NONE      = 32'hFFFF_FFFF;

    localparam logic [11:0] CSR_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_ADDR_MISA      = 12'h301;
    localparam logic [11:0] CSR_ADDR_MIE       = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_ADDR_MIP       = 12'h344;
    localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_ADDR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Clear the two low bits of a pc-like value (direct-mode / word alignment).
    function automatic logic [31:0] align4(input logic [31:0] v);
        return v & 32'hFFFF_FFFC;
    endfunction

endpackage : csr_file_pkg

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit counter with increment enable and per-half write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // A software write replaces one half and suppresses that cycle's increment.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule : csr_counter64

`default_nettype wire

// File: rtl/csr_file.sv
// ============================================================================
//  Module      : csr_file
//  Description : Machine-mode CSR file: trap state, counters, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wb,
    input  logic [31:0] pc,
    input  logic        trap,
    input  logic        mret,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    logic        w_addr_ok;
    logic [11:0] w_a;
    logic        w_we;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;

    assign w_addr_ok = (csr_addr[31:12] == 20'd0);
    assign w_a       = csr_addr[11:0];
    assign w_we      = csr_wb && w_addr_ok;

    always_comb begin
        w_mstatus                   = 32'd0;
        w_mstatus[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        w_mstatus[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    // Priority on mstatus: trap, then mret, then software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (w_we) begin
            case (w_a)
                CSR_ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_ADDR_MIE:      mie_d      = csr_wdata;
                CSR_ADDR_MTVEC:    mtvec_d    = align4(csr_wdata);
                CSR_ADDR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_ADDR_MEPC:     mepc_d     = align4(csr_wdata);
                CSR_ADDR_MCAUSE:   mcause_d   = csr_wdata;
                CSR_ADDR_MTVAL:    mtval_d    = csr_wdata;
                default: ;
            endcase
        end

        if (trap) begin
            mepc_d         = align4(pc);
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= 32'd0;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Only the machine-mode addresses are writable; user mirrors are read-only.
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (w_we && (w_a == CSR_ADDR_MCYCLE)),
        .wr_hi_i (w_we && (w_a == CSR_ADDR_MCYCLEH)),
        .wdata_i (csr_wdata),
        .count_o (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (retire),
        .wr_lo_i (w_we && (w_a == CSR_ADDR_MINSTRET)),
        .wr_hi_i (w_we && (w_a == CSR_ADDR_MINSTRETH)),
        .wdata_i (csr_wdata),
        .count_o (w_minstret)
    );

    always_comb begin
        csr_rdata = 32'd0;
        if (w_addr_ok) begin
            case (w_a)
                CSR_ADDR_MSTATUS:   csr_rdata = w_mstatus;
                CSR_ADDR_MISA:      csr_rdata = MISA_VAL;
                CSR_ADDR_MIE:       csr_rdata = mie_q;
                CSR_ADDR_MTVEC:     csr_rdata = mtvec_q;
                CSR_ADDR_MSCRATCH:  csr_rdata = mscratch_q;
                CSR_ADDR_MEPC:      csr_rdata = mepc_q;
                CSR_ADDR_MCAUSE:    csr_rdata = mcause_q;
                CSR_ADDR_MTVAL:     csr_rdata = mtval_q;
                CSR_ADDR_MIP:       csr_rdata = 32'd0;
                CSR_ADDR_MCYCLE,
                CSR_ADDR_CYCLE:     csr_rdata = w_mcycle[31:0];
                CSR_ADDR_MCYCLEH,
                CSR_ADDR_CYCLEH:    csr_rdata = w_mcycle[63:32];
                CSR_ADDR_MINSTRET,
                CSR_ADDR_INSTRET:   csr_rdata = w_minstret[31:0];
                CSR_ADDR_MINSTRETH,
                CSR_ADDR_INSTRETH:  csr_rdata = w_minstret[63:32];
                CSR_ADDR_MHARTID:   csr_rdata = HART_ID;
                default:            csr_rdata = 32'd0;
            endcase
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mstatus_mie_q;

endmodule : csr_file

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
//  Module      : tb_csr_file
//  Description : Directed scoreboard bench for csr_file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_file;

    localparam logic [31:0] C_HART_ID  = 32'h0000_0005;
    localparam logic [31:0] C_MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] C_NONE     = 32'hFFFF_FFFF;

    localparam int SEL_RDATA = 0;
    localparam int SEL_MTVEC = 1;
    localparam int SEL_MEPC  = 2;
    localparam int SEL_MIE   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wb;
    logic [31:0] pc;
    logic        trap;
    logic        mret;
    logic        retire;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    csr_file #(
        .HART_ID  (C_HART_ID),
        .MISA_VAL (C_MISA_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_wb    (csr_wb),
        .pc        (pc),
        .trap      (trap),
        .mret      (mret),
        .retire    (retire),
        .csr_rdata (csr_rdata),
        .mtvec_out (mtvec_out),
        .mepc_out  (mepc_out),
        .mie_out   (mie_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    // Monitor: outputs settle mid-cycle, so every queued expectation is checked on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            case (m_e.sel)
                SEL_MTVEC: m_act = mtvec_out;
                SEL_MEPC:  m_act = mepc_out;
                SEL_MIE:   m_act = {31'd0, mie_out};
                default:   m_act = csr_rdata;
            endcase
            checks++;
            if (m_act !== m_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic push(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        csr_wb = 1'b0;
        trap   = 1'b0;
        mret   = 1'b0;
        retire = 1'b0;
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] v);
        csr_addr = a;
        push(n, SEL_RDATA, v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wb    = 1'b1;
    endtask

    initial begin
        int t;
        rst = 1'b1; csr_addr = C_NONE; csr_wdata = 32'd0; csr_wb = 1'b0;
        pc = 32'd0; trap = 1'b0; mret = 1'b0; retire = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and counter run-up
        rd("rst_mstatus", 32'h300, 32'd0);
        push("rst_mtvec", SEL_MTVEC, 32'd0);
        push("rst_mepc",  SEL_MEPC,  32'd0);
        push("rst_mie",   SEL_MIE,   32'd0);
        repeat (10) step();
        rd("mcycle_10", 32'hB00, 32'd10);
        step(); rd("mcycleh_0", 32'hB80, 32'd0);
        step(); rd("cycle_12", 32'hC00, 32'd12);
        step(); rd("mstatus_0", 32'h300, 32'd0);
        step(); rd("mhartid", 32'hF14, C_HART_ID);
        step(); rd("misa", 32'h301, C_MISA_VAL);

        // mtvec alignment and write latency
        step(); wr(32'h305, 32'h0000_1003);
        push("mtvec_wcycle_rd", SEL_RDATA, 32'd0);
        push("mtvec_wcycle_out", SEL_MTVEC, 32'd0);
        step(); rd("mtvec_rd", 32'h305, 32'h0000_1000);
        push("mtvec_out", SEL_MTVEC, 32'h0000_1000);

        // Trap entry and MRET
        step(); wr(32'h300, 32'h0000_0008);
        step(); rd("mstatus_mie", 32'h300, 32'h0000_0008);
        push("mie_out_1", SEL_MIE, 32'd1);
        step(); pc = 32'h0000_0124; trap = 1'b1; wr(32'h342, 32'd11);
        push("mcause_wcycle", SEL_RDATA, 32'd0);
        step(); rd("mepc_trap", 32'h341, 32'h0000_0124);
        push("mepc_out_trap", SEL_MEPC, 32'h0000_0124);
        step(); rd("mcause_11", 32'h342, 32'd11);
        step(); rd("mstatus_trap", 32'h300, 32'h0000_0080);
        push("mie_out_trap", SEL_MIE, 32'd0);
        step(); mret = 1'b1; rd("mstatus_mret_cyc", 32'h300, 32'h0000_0080);
        step(); rd("mstatus_mret", 32'h300, 32'h0000_0088);
        push("mie_out_mret", SEL_MIE, 32'd1);
        step(); mret = 1'b1; wr(32'h300, 32'd0);
        step(); rd("mret_beats_write", 32'h300, 32'h0000_0088);
        step(); trap = 1'b1; mret = 1'b1; pc = 32'h0000_0040;
        step(); rd("trap_beats_mret", 32'h300, 32'h0000_0080);
        step(); mret = 1'b1;
        step(); rd("mstatus_restored", 32'h300, 32'h0000_0088);

        // Plain R/W registers and masking
        step(); wr(32'h304, 32'hA5A5_0F0F);
        step(); rd("mie_reg", 32'h304, 32'hA5A5_0F0F);
        step(); wr(32'h340, 32'hDEAD_BEEF);
        step(); rd("mscratch", 32'h340, 32'hDEAD_BEEF);
        step(); wr(32'h343, 32'h1234_5678);
        step(); rd("mtval", 32'h343, 32'h1234_5678);
        step(); wr(32'h341, 32'h0000_0503);
        step(); rd("mepc_sw_align", 32'h341, 32'h0000_0500);

        // Counter carry and read-only writes
        step(); wr(32'hB00, 32'hFFFF_FFFF);
        step(); rd("mcycle_wr", 32'hB00, 32'hFFFF_FFFF);
        step(); rd("mcycleh_carry", 32'hB80, 32'd1);
        step(); rd("cycleh_mirror", 32'hC80, 32'd1);
        step(); wr(32'h344, 32'h0000_0055);
        step(); rd("mip_ro", 32'h344, 32'd0);
        step(); wr(32'hC80, 32'h0000_0007);
        step(); rd("cycleh_ro", 32'hC80, 32'd1);
        step(); wr(32'hF14, 32'h0000_0099);
        step(); rd("mhartid_ro", 32'hF14, C_HART_ID);
        step(); rd("unmapped", 32'h0000_0123, 32'd0);
        step(); rd("addr_none", C_NONE, 32'd0);
        step(); rd("upper_bits", 32'h0000_1300, 32'd0);
        step(); csr_addr = 32'h0000_1304; csr_wdata = 32'd0; csr_wb = 1'b1;
        step(); rd("upper_bits_wr", 32'h304, 32'hA5A5_0F0F);

        // minstret
        step(); retire = 1'b1;
        step(); retire = 1'b1;
        step(); retire = 1'b1;
        step(); rd("minstret_3", 32'hB02, 32'd3);
        step(); rd("instret_3", 32'hC02, 32'd3);
        step(); rd("minstreth_0", 32'hB82, 32'd0);
        step(); wr(32'hB82, 32'h0000_0002); retire = 1'b1;
        step(); rd("minstreth_wr", 32'hB82, 32'd2);
        step(); rd("minstret_hold", 32'hB02, 32'd3);

        // Trap beats a mepc write, then reset mid-trap
        step(); pc = 32'h0000_0200; trap = 1'b1; wr(32'h341, 32'h0000_0500);
        step(); rd("mepc_trap_wins", 32'h341, 32'h0000_0200);
        push("mepc_out_200", SEL_MEPC, 32'h0000_0200);
        step(); rst = 1'b1; pc = 32'h0000_0300; trap = 1'b1;
        step(); rst = 1'b0;
        rd("rst2_mcycle", 32'hB00, 32'd0);
        push("rst2_mtvec", SEL_MTVEC, 32'd0);
        push("rst2_mepc",  SEL_MEPC,  32'd0);
        push("rst2_mie",   SEL_MIE,   32'd0);
        step(); rd("rst2_mstatus", 32'h300, 32'd0);
        step(); rd("rst2_mscratch", 32'h340, 32'd0);
        step(); rd("rst2_minstret", 32'hB02, 32'd0);
        step(); csr_addr = C_NONE;

        t = 0;
        while (sb_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_csr_file

`default_nettype wire
